key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Upstream input stage for the clock/display top. It turns raw push-button pins (mode key, add key) into clean, clock-domain-safe events that the top-level mode FSM and time-setting logic consume. Per key it provides:
- a two-flop synchroniser
- tick-based debounce
- one-cycle press and release pulses
- a debounced level
- a long-press auto-repeat pulse, used for fast minute/hour increment

Parameters:
- NUM_KEYS, 2: number of independent key channels; bit 0 = mode, bit 1 = add.
- TICK_DIV, 1024: clock cycles per debounce sample tick. Must be ≥2.
- DEBOUNCE_TICKS, 16: consecutive stable ticks needed to accept a press or a release. Must be ≥1.
- LONG_TICKS, 512: ticks in HELD before the first repeat pulse.
- REPEAT_TICKS, 64: ticks between subsequent repeat pulses. 0 disables repeat.
- KEY_ACTIVE_LOW, 1: 1 means the raw pin reads 0 when pressed.

Ports:
- clock, input, 1: system clock. This is the only clock.
- reset, input, 1: synchronous, active-low reset.
- key_in, input, NUM_KEYS: raw asynchronous key pins.
- key_level, output, NUM_KEYS: debounced state, 1 = pressed.
- key_down, output, NUM_KEYS: one-cycle pulse on accepted press.
- key_up, output, NUM_KEYS: one-cycle pulse on accepted release.
- key_repeat, output, NUM_KEYS: one-cycle pulse per auto-repeat interval while held.

Behaviour:
- Reset: all logic is sampled on the rising edge of clock while reset==0.
  - Outputs key_level, key_down, key_up and key_repeat reset to 0.
  - Synchroniser flops reset to the released pin level (1 when KEY_ACTIVE_LOW).
  - Prescaler, all counters and all FSMs clear to 0 / IDLE.
  - A reset in the middle of an operation aborts it and emits no pulse.
- Synchroniser: two flops per key, then inversion if KEY_ACTIVE_LOW, giving `p` (pressed). Latency is 2 cycles.
- Prescaler: one free-running counter shared by all keys, counting 0..TICK_DIV-1 and wrapping. `tick` is high for one cycle when the count equals TICK_DIV-1.
- Per-key FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT. Each key has:
  - a debounce counter `dcnt`
  - a hold counter `hcnt`, saturating at LONG_TICKS
  - a repeat counter `rcnt`
- IDLE:
  - If p==1, go to PRESS_WAIT with dcnt=0.
- PRESS_WAIT:
  - Any cycle with p==0: go to IDLE, dcnt=0.
  - On tick with p==1 and dcnt==DEBOUNCE_TICKS-1: go to HELD, assert key_down next cycle, set key_level=1, clear hcnt and rcnt.
  - Otherwise on tick with p==1: dcnt++.
- HELD:
  - Any cycle with p==0: go to REL_WAIT, dcnt=0.
  - On tick, if hcnt<LONG_TICKS: hcnt++. When hcnt becomes LONG_TICKS and REPEAT_TICKS≠0, pulse key_repeat and set rcnt=0.
  - On tick, if hcnt==LONG_TICKS and REPEAT_TICKS≠0: rcnt++. When rcnt reaches REPEAT_TICKS-1, pulse key_repeat and set rcnt=0.
- REL_WAIT:
  - Any cycle with p==1: return to HELD. hcnt and rcnt are kept, so a glitch does not reset the repeat cadence.
  - On tick with p==0 and dcnt==DEBOUNCE_TICKS-1: go to IDLE, pulse key_up, set key_level=0.
  - Otherwise on tick with p==0: dcnt++.
- Press timing: key_down arrives on the DEBOUNCE_TICKS-th tick after entry to PRESS_WAIT, plus 1 registered cycle.
- Pulses: all pulses are registered and last exactly one cycle. key_down and key_up are never asserted in the same cycle for one key. key_repeat never coincides with key_down.
- Independence: keys are fully independent. Simultaneous events on different keys produce pulses in the same cycle. There is no priority between keys.
- Widths: dcnt is $clog2(DEBOUNCE_TICKS+1) bits, hcnt is $clog2(LONG_TICKS+1) bits, rcnt is $clog2(REPEAT_TICKS+1) bits. All counters are unsigned and never wrap past their terminal value.

Decomposition:
- Shared package `key_pkg`:
  - state enum {IDLE, PRESS_WAIT, HELD, REL_WAIT}
  - default parameter constants
- Sub-module `key_channel`: synchroniser, FSM and counters for one key. It takes the shared tick as input and is instantiated NUM_KEYS times via generate.
- The prescaler stays in the top module.

Test Plan:
All tests use TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2, KEY_ACTIVE_LOW=1.
1. Reset with key held: key_in=2'b00 while reset=0 for 6 cycles → all outputs 0 throughout. After reset rises, exactly one key_down per key within 2+12+1=15 cycles.
2. Clean press: key_in[0] 1→0, held 40 cycles → exactly one key_down[0] pulse, key_level[0]=1. No key_down or key_level activity on key 1.
3. Bounce rejection: key_in[0] toggles every 3 cycles for 60 cycles → zero key_down/key_up pulses, key_level[0] stays 0.
4. Long press: key_in[1]=0 for 120 cycles → one key_down[1]. First key_repeat[1] 32 cycles (8 ticks) after key_down, then one every 8 cycles; count matches.
5. Release with glitch: after test 4, release key_in[1] with a 1-cycle 0 glitch mid-debounce → one key_up[1] 12–16 cycles after the last glitch, key_level[1]=0, repeats stop.
6. Simultaneous keys: both pins fall in the same cycle → key_down=2'b11 in a single cycle. Reset asserted mid-PRESS_WAIT → no pulse, FSMs return to IDLE.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, default parameters and counter-width helper for key conditioning.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } key_state_t;

   localparam int DEF_NUM_KEYS       = 2;
   localparam int DEF_TICK_DIV       = 1024;
   localparam int DEF_DEBOUNCE_TICKS = 16;
   localparam int DEF_LONG_TICKS     = 512;
   localparam int DEF_REPEAT_TICKS   = 64;
   localparam int DEF_KEY_ACTIVE_LOW = 1;

   // Width able to hold 0..n; never below one bit so a disabled feature still elaborates.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: synchroniser, debounce/hold/repeat FSM and registered event pulses for one key.
module key_channel
   import key_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int LONG_TICKS     = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
   parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
   input  logic clock,
   input  logic reset,
   input  logic tick,
   input  logic key_in,
   output logic level,
   output logic down,
   output logic up,
   output logic rep
);

   localparam int DW = cnt_width(DEBOUNCE_TICKS);
   localparam int HW = cnt_width(LONG_TICKS);
   localparam int RW = cnt_width(REPEAT_TICKS);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);
   localparam logic [HW-1:0] H_PRE  = HW'(LONG_TICKS - 1);
   localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);
   localparam logic          REL    = (KEY_ACTIVE_LOW != 0);

   logic [1:0]    sync;
   logic          p;
   key_state_t    state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic          level_n, down_n, up_n, rep_n;

   assign p = REL ? ~sync[1] : sync[1];

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync  <= {2{REL}};
         state <= IDLE;
         dcnt  <= '0;
         hcnt  <= '0;
         rcnt  <= '0;
         level <= 1'b0;
         down  <= 1'b0;
         up    <= 1'b0;
         rep   <= 1'b0;
      end else begin
         sync  <= {sync[0], key_in};
         state <= state_n;
         dcnt  <= dcnt_n;
         hcnt  <= hcnt_n;
         rcnt  <= rcnt_n;
         level <= level_n;
         down  <= down_n;
         up    <= up_n;
         rep   <= rep_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:       state_n = p ? PRESS_WAIT : IDLE;
         PRESS_WAIT: state_n = !p ? IDLE : (tick && dcnt == D_LAST) ? HELD : PRESS_WAIT;
         HELD:       state_n = !p ? REL_WAIT : HELD;
         REL_WAIT:   state_n = p ? HELD : (tick && dcnt == D_LAST) ? IDLE : REL_WAIT;
         default:    state_n = IDLE;
      endcase
   end

   // A p==1 cycle in REL_WAIT leaves hcnt/rcnt untouched so release glitches keep the repeat cadence.
   always_comb begin
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      rcnt_n  = rcnt;
      level_n = level;
      down_n  = 1'b0;
      up_n    = 1'b0;
      rep_n   = 1'b0;
      case (state)
         IDLE: dcnt_n = '0;
         PRESS_WAIT: begin
            if (!p) begin
               dcnt_n = '0;
            end else if (tick && dcnt == D_LAST) begin
               dcnt_n  = '0;
               hcnt_n  = '0;
               rcnt_n  = '0;
               level_n = 1'b1;
               down_n  = 1'b1;
            end else if (tick) begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         HELD: begin
            if (!p) begin
               dcnt_n = '0;
            end else if (tick && hcnt != H_MAX) begin
               hcnt_n = hcnt + 1'b1;
               if (hcnt == H_PRE && REPEAT_TICKS != 0) begin
                  rep_n  = 1'b1;
                  rcnt_n = '0;
               end
            end else if (tick && REPEAT_TICKS != 0) begin
               rep_n  = (rcnt == R_LAST);
               rcnt_n = (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
            end
         end
         REL_WAIT: begin
            if (!p && tick && dcnt == D_LAST) begin
               dcnt_n  = '0;
               level_n = 1'b0;
               up_n    = 1'b1;
            end else if (!p && tick) begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         default: dcnt_n = '0;
      endcase
   end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: shared debounce prescaler feeding one independent conditioning channel per key.
module key_conditioner
   import key_pkg::*;
#(
   parameter int NUM_KEYS       = DEF_NUM_KEYS,
   parameter int TICK_DIV       = DEF_TICK_DIV,
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int LONG_TICKS     = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
   parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_down,
   output logic [NUM_KEYS-1:0] key_up,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] pcnt;
   logic          tick;

   assign tick = (pcnt == T_LAST);

   always_ff @(posedge clock) begin
      if (!reset) pcnt <= '0;
      else        pcnt <= tick ? '0 : pcnt + 1'b1;
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_channel #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
         .LONG_TICKS    (LONG_TICKS),
         .REPEAT_TICKS  (REPEAT_TICKS),
         .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
      ) u_ch (
         .clock (clock),
         .reset (reset),
         .tick  (tick),
         .key_in(key_in[k]),
         .level (key_level[k]),
         .down  (key_down[k]),
         .up    (key_up[k]),
         .rep   (key_repeat[k])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed vector table plus hand-timed sequences for debounce, repeat and reset.
module tb_key_conditioner;

   logic       clock;
   logic       reset;
   logic [1:0] key_in;
   logic [1:0] key_level, key_down, key_up, key_repeat;

   key_conditioner #(
      .NUM_KEYS(2), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
      .LONG_TICKS(8), .REPEAT_TICKS(2), .KEY_ACTIVE_LOW(1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .key_in    (key_in),
      .key_level (key_level),
      .key_down  (key_down),
      .key_up    (key_up),
      .key_repeat(key_repeat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Event counters, written only by the monitor; the stimulus takes snapshots.
   int   ncyc = 0;
   int   n_down[2] = '{0, 0};
   int   n_up[2]   = '{0, 0};
   int   n_rep[2]  = '{0, 0};
   int   both_down = 0, split_down = 0, viol = 0, rst_act = 0;
   int   down1_cyc = 0, up1_cyc = 0, last_rep = 0;
   int   first_gap = -1, min_gap = 1000000, max_gap = 0;
   logic rst_q;
   logic [1:0] down_q = 2'b00, up_q = 2'b00, rep_q = 2'b00;

   always @(posedge clock) rst_q <= reset;

   always @(negedge clock) begin
      ncyc <= ncyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (key_down[k] === 1'b1)   n_down[k] <= n_down[k] + 1;
         if (key_up[k] === 1'b1)     n_up[k]   <= n_up[k] + 1;
         if (key_repeat[k] === 1'b1) n_rep[k]  <= n_rep[k] + 1;
      end
      if (key_down == 2'b11) both_down <= both_down + 1;
      if (key_down == 2'b01 || key_down == 2'b10) split_down <= split_down + 1;
      if ((key_down & key_up) != 0 || (key_down & key_repeat) != 0 ||
          (key_down & down_q) != 0 || (key_up & up_q) != 0 || (key_repeat & rep_q) != 0)
         viol <= viol + 1;
      down_q <= key_down;
      up_q   <= key_up;
      rep_q  <= key_repeat;
      if (rst_q === 1'b0 && (key_level | key_down | key_up | key_repeat) != 0) rst_act <= rst_act + 1;
      if (key_down[1] === 1'b1) down1_cyc <= ncyc;
      if (key_up[1] === 1'b1)   up1_cyc   <= ncyc;
      if (key_repeat[1] === 1'b1) begin
         if (n_rep[1] == 0) first_gap <= ncyc - down1_cyc;
         else begin
            if (ncyc - last_rep < min_gap) min_gap <= ncyc - last_rep;
            if (ncyc - last_rep > max_gap) max_gap <= ncyc - last_rep;
         end
         last_rep <= ncyc;
      end
   end

   int errors = 0, checks = 0;
   int b_down[2], b_up[2], b_rep[2];
   int b_both, b_split, glitch_cyc;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_range(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic snap();
      for (int k = 0; k < 2; k++) begin
         b_down[k] = n_down[k];
         b_up[k]   = n_up[k];
         b_rep[k]  = n_rep[k];
      end
      b_both  = both_down;
      b_split = split_down;
   endtask

   typedef struct {
      logic [1:0] key;
      logic [1:0] tog;
      int         cycles;
      int         dn0, dn1, up0, up1, rp0, rp1;
      logic [1:0] lvl;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{2'b11, 2'b00, 24, 0, 0, 1, 1, 0, 0, 2'b00};
      vt[1] = '{2'b10, 2'b00, 40, 1, 0, 0, 0, 0, 0, 2'b01};
      vt[2] = '{2'b11, 2'b00, 30, 0, 0, 1, 0, 0, 0, 2'b00};
      vt[3] = '{2'b11, 2'b01, 60, 0, 0, 0, 0, 0, 0, 2'b00};
      vt[4] = '{2'b11, 2'b00, 12, 0, 0, 0, 0, 0, 0, 2'b00};
      vt[5] = '{2'b01, 2'b00, 30, 0, 1, 0, 0, 0, 0, 2'b10};

      // Keys held through reset: silent while reset, one press each afterwards.
      reset  = 1'b0;
      key_in = 2'b00;
      cyc(6);
      chk("reset_quiet", rst_act, 0);
      reset = 1'b1;
      snap();
      cyc(15);
      chk("rst_held_down0", n_down[0] - b_down[0], 1);
      chk("rst_held_down1", n_down[1] - b_down[1], 1);

      for (int i = 0; i < 6; i++) begin
         snap();
         for (int c = 0; c < vt[i].cycles; c++) begin
            key_in = vt[i].key ^ ((((c / 3) % 2) == 1) ? vt[i].tog : 2'b00);
            cyc(1);
         end
         chk($sformatf("v%0d_down0", i), n_down[0] - b_down[0], vt[i].dn0);
         chk($sformatf("v%0d_down1", i), n_down[1] - b_down[1], vt[i].dn1);
         chk($sformatf("v%0d_up0", i),   n_up[0] - b_up[0],     vt[i].up0);
         chk($sformatf("v%0d_up1", i),   n_up[1] - b_up[1],     vt[i].up1);
         chk($sformatf("v%0d_rep0", i),  n_rep[0] - b_rep[0],   vt[i].rp0);
         chk($sformatf("v%0d_rep1", i),  n_rep[1] - b_rep[1],   vt[i].rp1);
         chk($sformatf("v%0d_level", i), int'(key_level),       int'(vt[i].lvl));
      end

      // Long press on key 1 from a known prescaler phase, then release with a glitch.
      reset  = 1'b0;
      key_in = 2'b11;
      cyc(3);
      reset  = 1'b1;
      key_in = 2'b01;
      snap();
      cyc(118);
      chk("long_level", int'(key_level), 2);
      key_in = 2'b11;
      cyc(5);
      glitch_cyc = ncyc;
      key_in = 2'b01;
      cyc(1);
      key_in = 2'b11;
      cyc(30);
      chk("long_down1", n_down[1] - b_down[1], 1);
      chk("long_down0", n_down[0] - b_down[0], 0);
      chk("long_rep1", n_rep[1] - b_rep[1], 10);
      chk("long_first_gap", first_gap, 32);
      chk("long_min_gap", min_gap, 8);
      chk("long_max_gap", max_gap, 8);
      chk("glitch_up1", n_up[1] - b_up[1], 1);
      chk_range("glitch_up_delay", up1_cyc - glitch_cyc, 12, 16);
      chk("glitch_level", int'(key_level), 0);

      // Both keys fall together.
      snap();
      key_in = 2'b00;
      cyc(24);
      chk("simul_both", both_down - b_both, 1);
      chk("simul_split", split_down - b_split, 0);
      chk("simul_level", int'(key_level), 3);
      key_in = 2'b11;
      cyc(30);
      chk("simul_up0", n_up[0] - b_up[0], 1);
      chk("simul_up1", n_up[1] - b_up[1], 1);
      chk("simul_rel_level", int'(key_level), 0);

      // Reset during PRESS_WAIT aborts without any pulse.
      snap();
      key_in = 2'b00;
      cyc(6);
      reset  = 1'b0;
      key_in = 2'b11;
      cyc(2);
      reset  = 1'b1;
      cyc(30);
      chk("abort_pulses", (n_down[0] - b_down[0]) + (n_down[1] - b_down[1]) +
                          (n_up[0] - b_up[0]) + (n_up[1] - b_up[1]) +
                          (n_rep[0] - b_rep[0]) + (n_rep[1] - b_rep[1]), 0);
      chk("abort_level", int'(key_level), 0);

      chk("pulse_rules", viol, 0);
      chk("reset_quiet_all", rst_act, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
